// File: rtl/output_collector.sv
// Collects output-neuron results into a FIFO: tracks in-flight samples, captures y with a class bit.
// Optional per-capture statistics counters are enabled by OUTPUT_COLLECTOR_STATS_EN.
module output_collector #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PIPE_LAT = 4,
    parameter int unsigned DEPTH    = 8,
    parameter logic signed [WIDTH-1:0] THRESH = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         y,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_class,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
`ifdef OUTPUT_COLLECTOR_STATS_EN
    ,
    output logic [15:0]              sample_cnt,
    output logic [15:0]              pos_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PIPE_LAT-1:0] tracker;
    logic [PIPE_LAT-1:0] tracker_shift;
    logic                capture_c;
    logic                cls_c;
    logic                push_c;
    logic                pop_c;
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic [WIDTH:0]      mem [DEPTH];
    logic [WIDTH:0]      head;

    // A sample's tail bit lines up with its y on the neuron output.
    assign tracker_shift = (tracker << 1) | PIPE_LAT'(in_valid);
    assign capture_c     = en & tracker[PIPE_LAT-1];
    assign cls_c         = $signed(y) >= THRESH;
    assign pop_c         = ~empty & out_ready;
    assign push_c        = capture_c & (~full | pop_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            tracker <= '0;
        end else if (en) begin
            tracker <= tracker_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_c) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_c) begin
                rptr <= rptr + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow <= overflow | (capture_c & full & ~pop_c);
        end
    end

    // Storage is not reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            mem[wptr] <= {y, cls_c};
        end
    end

    assign head      = mem[rptr];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : head[WIDTH:1];
    assign out_class = ~empty & head[0];

`ifdef OUTPUT_COLLECTOR_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
            pos_cnt    <= '0;
        end else if (capture_c) begin
            if (sample_cnt != 16'hFFFF) begin
                sample_cnt <= sample_cnt + 16'd1;
            end
            if (cls_c && pos_cnt != 16'hFFFF) begin
                pos_cnt <= pos_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
